// File: rtl/tnoc_axi_pkg.sv
// ----------------------------------------------------------------------------
// tnoc_axi_pkg
//
// Shared AXI definitions for the burst address generator slice:
//   - tnoc_axi_config / TNOC_DEFAULT_AXI_CONFIG : bus geometry (address and
//     data width) handed to modules as a single struct parameter
//   - burst field types (length, size, type) in AXI encoding
//   - tnoc_axi_burst_state : generator FSM states (IDLE, BURST)
//   - unpack_burst_length   : AXI packed length (beats-1) -> beat count
//   - is_valid_wrap_length  : WRAP is only legal for 2, 4, 8 or 16 beats
//   - calc_wrap_boundary    : lower wrap boundary floor(addr/W)*W
// ----------------------------------------------------------------------------
package tnoc_axi_pkg;

    // Widest address any instance may use; the helper functions below work
    // at this width and callers truncate the result to their own width.
    localparam int TNOC_AXI_MAX_ADDRESS_WIDTH = 64;

    typedef struct packed {
        int address_width;
        int data_width;
    } tnoc_axi_config;

    localparam tnoc_axi_config TNOC_DEFAULT_AXI_CONFIG = '{
        address_width: 32,
        data_width:    32
    };

    typedef logic [7:0] tnoc_axi_burst_length;
    typedef logic [2:0] tnoc_axi_burst_size;

    typedef enum logic [1:0] {
        TNOC_AXI_FIXED_BURST    = 2'b00,
        TNOC_AXI_INCR_BURST     = 2'b01,
        TNOC_AXI_WRAP_BURST     = 2'b10,
        TNOC_AXI_RESERVED_BURST = 2'b11
    } tnoc_axi_burst_type;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } tnoc_axi_burst_state;

    // Packed length holds beats-1; one extra bit is needed for 256 beats.
    function automatic logic [8:0] unpack_burst_length(
        input tnoc_axi_burst_length burst_length
    );
        return {1'b0, burst_length} + 9'd1;
    endfunction

    function automatic logic is_valid_wrap_length(
        input tnoc_axi_burst_length burst_length
    );
        return (burst_length == 8'd1) || (burst_length == 8'd3) ||
               (burst_length == 8'd7) || (burst_length == 8'd15);
    endfunction

    // The wrap span W = beats * 2^size is a power of two for every legal WRAP
    // length, so floor(address/W)*W reduces to clearing the low bits.
    function automatic logic [TNOC_AXI_MAX_ADDRESS_WIDTH-1:0] calc_wrap_boundary(
        input logic [TNOC_AXI_MAX_ADDRESS_WIDTH-1:0] address,
        input logic [8:0]                            beats,
        input tnoc_axi_burst_size                    burst_size
    );
        logic [TNOC_AXI_MAX_ADDRESS_WIDTH-1:0] span;
        span = TNOC_AXI_MAX_ADDRESS_WIDTH'(beats) << burst_size;
        return address & ~(span - TNOC_AXI_MAX_ADDRESS_WIDTH'(1));
    endfunction

endpackage

// File: rtl/tnoc_axi_next_address.sv
// ----------------------------------------------------------------------------
// tnoc_axi_next_address
//
// Purely combinational next-beat address calculation.
//
// Parameters:
//   ADDRESS_WIDTH : address bus width
// Ports:
//   address      in  current beat address
//   burst_size   in  effective (already clamped) transfer size, log2 bytes
//   burst_type   in  effective burst type (FIXED / INCR / WRAP)
//   wrap_lower   in  wrap boundary B
//   wrap_upper   in  B + W (one past the wrap window)
//   next_address out address of the following beat
// ----------------------------------------------------------------------------
module tnoc_axi_next_address
    import tnoc_axi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
)(
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [2:0]               burst_size,
    input  logic [1:0]               burst_type,
    input  logic [ADDRESS_WIDTH-1:0] wrap_lower,
    input  logic [ADDRESS_WIDTH-1:0] wrap_upper,
    output logic [ADDRESS_WIDTH-1:0] next_address
);

    logic [ADDRESS_WIDTH-1:0] step;
    logic [ADDRESS_WIDTH-1:0] incremented;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path leaves it unassigned and no latch is inferred.
        step         = ADDRESS_WIDTH'(1) << burst_size;
        // Only the first beat may be unaligned; later beats sit on size
        // boundaries. The sum wraps naturally modulo 2^ADDRESS_WIDTH.
        incremented  = (address & ~(step - ADDRESS_WIDTH'(1))) + step;
        next_address = incremented;
        case (burst_type)
            TNOC_AXI_FIXED_BURST: next_address = address;
            TNOC_AXI_WRAP_BURST: begin
                if (incremented == wrap_upper) begin
                    next_address = wrap_lower;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tnoc_axi_burst_address_generator.sv
// ----------------------------------------------------------------------------
// tnoc_axi_burst_address_generator
//
// Accepts one AXI burst command at a time and emits one beat per handshake,
// carrying the beat address, its index and a last-beat flag. A new command
// can be taken in the same cycle as the last-beat handshake, so back-to-back
// bursts stream without a bubble.
//
// Parameters:
//   AXI_CONFIG : address_width / data_width of the bus
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_cmd_valid/o_cmd_ready   command handshake
//   i_cmd_address         start address (may be unaligned)
//   i_cmd_burst_length    beats-1
//   i_cmd_burst_size      log2 bytes per beat (clamped to bus width)
//   i_cmd_burst_type      FIXED / INCR / WRAP (reserved and illegal WRAP
//                         lengths behave as INCR)
//   o_beat_valid/i_beat_ready beat handshake
//   o_beat_address        address of the current beat
//   o_beat_index          zero-based beat number
//   o_beat_last           final beat of the burst
//   o_byte_offset         beat address modulo bus bytes
//   o_boundary_error      INCR burst crosses a 4KB page
//
// Build option: define TNOC_AXI_4KB_BOUNDARY_CHECK_EN to enable the 4KB
// crossing check; otherwise o_boundary_error is tied to 0.
// ----------------------------------------------------------------------------
module tnoc_axi_burst_address_generator
    import tnoc_axi_pkg::*;
#(
    parameter tnoc_axi_pkg::tnoc_axi_config AXI_CONFIG = tnoc_axi_pkg::TNOC_DEFAULT_AXI_CONFIG
)(
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_cmd_valid,
    output logic                                       o_cmd_ready,
    input  logic [AXI_CONFIG.address_width-1:0]        i_cmd_address,
    input  logic [7:0]                                 i_cmd_burst_length,
    input  logic [2:0]                                 i_cmd_burst_size,
    input  logic [1:0]                                 i_cmd_burst_type,
    output logic                                       o_beat_valid,
    input  logic                                       i_beat_ready,
    output logic [AXI_CONFIG.address_width-1:0]        o_beat_address,
    output logic [7:0]                                 o_beat_index,
    output logic                                       o_beat_last,
    output logic [$clog2(AXI_CONFIG.data_width/8)-1:0] o_byte_offset,
    output logic                                       o_boundary_error
);

    localparam int         ADDRESS_WIDTH = AXI_CONFIG.address_width;
    localparam int         BUS_BYTES     = AXI_CONFIG.data_width / 8;
    localparam int         OFFSET_WIDTH  = $clog2(BUS_BYTES);
    localparam logic [2:0] MAX_SIZE      = 3'(OFFSET_WIDTH);

    tnoc_axi_burst_state      state;
    tnoc_axi_burst_state      state_next;

    // Latched burst context
    logic [ADDRESS_WIDTH-1:0] beat_address;
    logic [7:0]               beat_index;
    logic [7:0]               burst_length;
    logic [2:0]               burst_size;
    logic [1:0]               burst_type;
    logic [ADDRESS_WIDTH-1:0] wrap_lower;
    logic [ADDRESS_WIDTH-1:0] wrap_upper;

    logic                     beat_valid;
    logic                     beat_last;
    logic                     beat_done;
    logic                     cmd_ready;
    logic                     cmd_accept;
    logic [ADDRESS_WIDTH-1:0] next_address;

    // Decoded incoming command
    logic [8:0]               cmd_beats;
    logic [2:0]               cmd_size;
    logic [1:0]               cmd_type;
    logic [ADDRESS_WIDTH-1:0] cmd_span;
    logic [ADDRESS_WIDTH-1:0] cmd_wrap_lower;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign beat_valid = (state == BURST);
    assign beat_last  = beat_valid && (beat_index == burst_length);
    assign beat_done  = beat_valid && i_beat_ready;
    assign cmd_ready  = (state == IDLE) || (beat_done && beat_last);
    assign cmd_accept = i_cmd_valid && cmd_ready;

    // ------------------------------------------------------------------
    // Command decode: clamp size, demote reserved / illegal WRAP to INCR,
    // precompute the wrap window so the beat path stays short.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_beats = unpack_burst_length(i_cmd_burst_length);
        cmd_size  = (i_cmd_burst_size > MAX_SIZE) ? MAX_SIZE : i_cmd_burst_size;
        cmd_type  = TNOC_AXI_INCR_BURST;
        case (i_cmd_burst_type)
            TNOC_AXI_FIXED_BURST: cmd_type = TNOC_AXI_FIXED_BURST;
            TNOC_AXI_WRAP_BURST: begin
                if (is_valid_wrap_length(i_cmd_burst_length)) begin
                    cmd_type = TNOC_AXI_WRAP_BURST;
                end
            end
            default: ;
        endcase
        cmd_span       = ADDRESS_WIDTH'(cmd_beats) << cmd_size;
        cmd_wrap_lower = ADDRESS_WIDTH'(calc_wrap_boundary(
            TNOC_AXI_MAX_ADDRESS_WIDTH'(i_cmd_address), cmd_beats, cmd_size));
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_cmd_valid) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                // A command arriving with the last handshake keeps us in BURST.
                if (beat_done && beat_last && !i_cmd_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: the datapath registers are reset as well, because the beat
        // address and index are visible outputs that must read 0 in reset.
        if (i_rst) begin
            beat_address <= '0;
            beat_index   <= '0;
            burst_length <= '0;
            burst_size   <= '0;
            burst_type   <= '0;
            wrap_lower   <= '0;
            wrap_upper   <= '0;
        end else if (cmd_accept) begin
            beat_address <= i_cmd_address;
            beat_index   <= '0;
            burst_length <= i_cmd_burst_length;
            burst_size   <= cmd_size;
            burst_type   <= cmd_type;
            wrap_lower   <= cmd_wrap_lower;
            wrap_upper   <= cmd_wrap_lower + cmd_span;
        end else if (beat_done && !beat_last) begin
            beat_address <= next_address;
            beat_index   <= beat_index + 8'd1;
        end
    end

    tnoc_axi_next_address #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_next_address (
        .address      (beat_address),
        .burst_size   (burst_size),
        .burst_type   (burst_type),
        .wrap_lower   (wrap_lower),
        .wrap_upper   (wrap_upper),
        .next_address (next_address)
    );

    // ------------------------------------------------------------------
    // 4KB page crossing check
    // ------------------------------------------------------------------
`ifdef TNOC_AXI_4KB_BOUNDARY_CHECK_EN
    logic [ADDRESS_WIDTH-1:0] cmd_size_mask;
    logic [ADDRESS_WIDTH-1:0] cmd_last_byte;
    logic                     cmd_crosses_4kb;
    logic                     boundary_error;

    always_comb begin
        cmd_size_mask   = (ADDRESS_WIDTH'(1) << cmd_size) - ADDRESS_WIDTH'(1);
        cmd_last_byte   = (i_cmd_address & ~cmd_size_mask) + cmd_span - ADDRESS_WIDTH'(1);
        // Compare page numbers by shifting rather than slicing so every
        // address bit takes part; a wrap past the top of the address space
        // lands in a different page and is flagged too.
        cmd_crosses_4kb = (cmd_type == TNOC_AXI_INCR_BURST) &&
                          ((cmd_last_byte >> 12) != (i_cmd_address >> 12));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            boundary_error <= 1'b0;
        end else if (cmd_accept) begin
            boundary_error <= cmd_crosses_4kb;
        end
    end

    assign o_boundary_error = beat_valid && boundary_error;
`else
    assign o_boundary_error = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_cmd_ready    = cmd_ready;
    assign o_beat_valid   = beat_valid;
    assign o_beat_address = beat_address;
    assign o_beat_index   = beat_index;
    assign o_beat_last    = beat_last;
    assign o_byte_offset  = beat_address[OFFSET_WIDTH-1:0];

endmodule

// File: tb/tb_tnoc_axi_burst_address_generator.sv
// ----------------------------------------------------------------------------
// Directed testbench for tnoc_axi_burst_address_generator (32-bit address,
// 32-bit data). Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge. Beat observations are packed as
// {valid, last, boundary_error, index[7:0], address[31:0]}.
// Expected 4KB flag follows TNOC_AXI_4KB_BOUNDARY_CHECK_EN.
// ----------------------------------------------------------------------------
module tb_tnoc_axi_burst_address_generator;
    import tnoc_axi_pkg::*;

`ifdef TNOC_AXI_4KB_BOUNDARY_CHECK_EN
    localparam logic EXP_4KB_ERROR = 1'b1;
`else
    localparam logic EXP_4KB_ERROR = 1'b0;
`endif

    localparam logic [1:0] T_FIXED = 2'b00;
    localparam logic [1:0] T_INCR  = 2'b01;
    localparam logic [1:0] T_WRAP  = 2'b10;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [31:0] i_cmd_address;
    logic [7:0]  i_cmd_burst_length;
    logic [2:0]  i_cmd_burst_size;
    logic [1:0]  i_cmd_burst_type;
    logic        o_beat_valid;
    logic        i_beat_ready;
    logic [31:0] o_beat_address;
    logic [7:0]  o_beat_index;
    logic        o_beat_last;
    logic [1:0]  o_byte_offset;
    logic        o_boundary_error;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 i_clk = ~i_clk;

    tnoc_axi_burst_address_generator #(
        .AXI_CONFIG (TNOC_DEFAULT_AXI_CONFIG)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_cmd_valid        (i_cmd_valid),
        .o_cmd_ready        (o_cmd_ready),
        .i_cmd_address      (i_cmd_address),
        .i_cmd_burst_length (i_cmd_burst_length),
        .i_cmd_burst_size   (i_cmd_burst_size),
        .i_cmd_burst_type   (i_cmd_burst_type),
        .o_beat_valid       (o_beat_valid),
        .i_beat_ready       (i_beat_ready),
        .o_beat_address     (o_beat_address),
        .o_beat_index       (o_beat_index),
        .o_beat_last        (o_beat_last),
        .o_byte_offset      (o_byte_offset),
        .o_boundary_error   (o_boundary_error)
    );

    // Stimulus only: present a command on the command port.
    task automatic drive_cmd(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] btype);
        i_cmd_valid        = 1'b1;
        i_cmd_address      = addr;
        i_cmd_burst_length = len;
        i_cmd_burst_size   = size;
        i_cmd_burst_type   = btype;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_compared++;
        if ({o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address} !== 43'd0) begin
            n_mismatched++;
            $display("FAIL reset_beat_outputs: got v=%b l=%b e=%b idx=%0d addr=%h want all zero",
                     o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address);
        end
        n_compared++;
        if (o_cmd_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic test_incr();
        logic [31:0] exp_addr [4];
        logic [1:0]  exp_off  [4];
        logic [42:0] got, exp;
        exp_addr = '{32'h1002, 32'h1004, 32'h1008, 32'h100C};
        exp_off  = '{2'd2, 2'd0, 2'd0, 2'd0};
        @(posedge i_clk); #1;
        drive_cmd(32'h1002, 8'd3, 3'd2, T_INCR);
        @(negedge i_clk);
        n_compared++;
        if (o_cmd_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL incr_cmd_ready: got %b want 1", o_cmd_ready);
        end
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
            exp = {1'b1, (i == 3), 1'b0, 8'(i), exp_addr[i]};
            n_compared++;
            if (got !== exp) begin
                n_mismatched++;
                $display("FAIL incr_beat%0d: got %h want %h", i, got, exp);
            end
            n_compared++;
            if (o_byte_offset !== exp_off[i]) begin
                n_mismatched++;
                $display("FAIL incr_offset%0d: got %0d want %0d", i, o_byte_offset, exp_off[i]);
            end
        end
        @(negedge i_clk);
        n_compared++;
        if ({o_beat_valid, o_cmd_ready} !== 2'b01) begin
            n_mismatched++;
            $display("FAIL incr_idle_after: got valid=%b ready=%b want valid=0 ready=1",
                     o_beat_valid, o_cmd_ready);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [4];
        logic [42:0] got, exp;
        exp_addr = '{32'h108, 32'h10C, 32'h100, 32'h104};
        @(posedge i_clk); #1;
        drive_cmd(32'h108, 8'd3, 3'd2, T_WRAP);
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
            exp = {1'b1, (i == 3), 1'b0, 8'(i), exp_addr[i]};
            n_compared++;
            if (got !== exp) begin
                n_mismatched++;
                $display("FAIL wrap_beat%0d: got %h want %h", i, got, exp);
            end
        end
        @(negedge i_clk);
        n_compared++;
        if (o_beat_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL wrap_idle_after: got valid=%b want 0", o_beat_valid);
        end
    endtask

    task automatic test_fixed();
        logic [42:0] got, exp;
        @(posedge i_clk); #1;
        drive_cmd(32'h20, 8'd2, 3'd2, T_FIXED);
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
            exp = {1'b1, (i == 2), 1'b0, 8'(i), 32'h20};
            n_compared++;
            if (got !== exp) begin
                n_mismatched++;
                $display("FAIL fixed_beat%0d: got %h want %h", i, got, exp);
            end
        end
        @(negedge i_clk);
        n_compared++;
        if (o_beat_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL fixed_idle_after: got valid=%b want 0", o_beat_valid);
        end
    endtask

    // Stall on beat 1, then chain a new command onto the last-beat handshake.
    task automatic test_back_to_back();
        logic [42:0] got, exp;
        @(posedge i_clk); #1;
        drive_cmd(32'h200, 8'd3, 3'd2, T_INCR);
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        @(negedge i_clk);
        got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
        exp = {1'b1, 1'b0, 1'b0, 8'd0, 32'h200};
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL b2b_beat0: got %h want %h", got, exp);
        end
        @(posedge i_clk); #1;
        i_beat_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
            exp = {1'b1, 1'b0, 1'b0, 8'd1, 32'h204};
            n_compared++;
            if (got !== exp) begin
                n_mismatched++;
                $display("FAIL b2b_stall_hold%0d: got %h want %h", k, got, exp);
            end
        end
        i_beat_ready = 1'b1;
        @(negedge i_clk);
        got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
        exp = {1'b1, 1'b0, 1'b0, 8'd2, 32'h208};
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL b2b_beat2: got %h want %h", got, exp);
        end
        @(negedge i_clk);
        got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
        exp = {1'b1, 1'b1, 1'b0, 8'd3, 32'h20C};
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL b2b_beat3_last: got %h want %h", got, exp);
        end
        drive_cmd(32'h300, 8'd1, 3'd2, T_INCR);
        #1;
        n_compared++;
        if (o_cmd_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL b2b_ready_on_last: got %b want 1", o_cmd_ready);
        end
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        @(negedge i_clk);
        got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
        exp = {1'b1, 1'b0, 1'b0, 8'd0, 32'h300};
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL b2b_new_beat0: got %h want %h", got, exp);
        end
        @(negedge i_clk);
        got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
        exp = {1'b1, 1'b1, 1'b0, 8'd1, 32'h304};
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL b2b_new_beat1: got %h want %h", got, exp);
        end
        @(negedge i_clk);
        n_compared++;
        if (o_beat_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL b2b_idle_after: got valid=%b want 0", o_beat_valid);
        end
    endtask

    task automatic test_4kb_boundary();
        logic [31:0] exp_addr [4];
        logic [42:0] got, exp;
        exp_addr = '{32'hFF8, 32'hFFC, 32'h1000, 32'h1004};
        @(posedge i_clk); #1;
        drive_cmd(32'hFF8, 8'd3, 3'd2, T_INCR);
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
            exp = {1'b1, (i == 3), EXP_4KB_ERROR, 8'(i), exp_addr[i]};
            n_compared++;
            if (got !== exp) begin
                n_mismatched++;
                $display("FAIL 4kb_beat%0d: got %h want %h", i, got, exp);
            end
        end
        @(negedge i_clk);
        n_compared++;
        if ({o_beat_valid, o_boundary_error} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL 4kb_idle_after: got valid=%b err=%b want 0 0",
                     o_beat_valid, o_boundary_error);
        end
    endtask

    // Size 16B on a 4B bus is clamped; WRAP with 3 beats behaves as INCR.
    task automatic test_clamp_and_demote();
        logic [31:0] exp_addr [3];
        logic [42:0] got, exp;
        @(posedge i_clk); #1;
        drive_cmd(32'h40, 8'd1, 3'd4, T_INCR);
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
            exp = {1'b1, (i == 1), 1'b0, 8'(i), 32'h40 + 32'(4 * i)};
            n_compared++;
            if (got !== exp) begin
                n_mismatched++;
                $display("FAIL clamp_beat%0d: got %h want %h", i, got, exp);
            end
        end
        exp_addr = '{32'h10C, 32'h110, 32'h114};
        @(posedge i_clk); #1;
        drive_cmd(32'h10C, 8'd2, 3'd2, T_WRAP);
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
            exp = {1'b1, (i == 2), 1'b0, 8'(i), exp_addr[i]};
            n_compared++;
            if (got !== exp) begin
                n_mismatched++;
                $display("FAIL wrap3_as_incr_beat%0d: got %h want %h", i, got, exp);
            end
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid_burst();
        logic [42:0] got, exp;
        @(posedge i_clk); #1;
        drive_cmd(32'h400, 8'd3, 3'd2, T_INCR);
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
        exp = {1'b1, 1'b0, 1'b0, 8'd1, 32'h404};
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL rstmid_beat1: got %h want %h", got, exp);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
        n_compared++;
        if ({got, o_cmd_ready} !== {43'd0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL rstmid_after_reset: got %h ready=%b want 0 ready=1", got, o_cmd_ready);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        n_compared++;
        if (o_beat_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL rstmid_no_stale_beat: got valid=%b want 0", o_beat_valid);
        end
        @(posedge i_clk); #1;
        drive_cmd(32'h500, 8'd0, 3'd2, T_INCR);
        @(negedge i_clk);
        n_compared++;
        if (o_cmd_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL rstmid_new_cmd_ready: got %b want 1", o_cmd_ready);
        end
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        @(negedge i_clk);
        got = {o_beat_valid, o_beat_last, o_boundary_error, o_beat_index, o_beat_address};
        exp = {1'b1, 1'b1, 1'b0, 8'd0, 32'h500};
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL rstmid_single_beat: got %h want %h", got, exp);
        end
        @(negedge i_clk);
        n_compared++;
        if (o_beat_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL rstmid_idle_after: got valid=%b want 0", o_beat_valid);
        end
    endtask

    initial begin
        i_rst              = 1'b1;
        i_cmd_valid        = 1'b0;
        i_cmd_address      = '0;
        i_cmd_burst_length = '0;
        i_cmd_burst_size   = '0;
        i_cmd_burst_type   = '0;
        i_beat_ready       = 1'b1;

        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_back_to_back();
        test_4kb_boundary();
        test_clamp_and_demote();
        test_reset_mid_burst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
